// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl_if
// Description : CPU fetch port and backing-memory port of the I-cache refill
//               controller, bundled for connection between CPU/memory and cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if;
    logic        rd_req;
    logic [31:2] addr;
    logic        flush;
    logic [31:0] rd_data;
    logic        miss;
    logic [31:2] mem_addr;
    logic [31:0] mem_data;

    // CPU plus backing memory side
    modport master (
        output rd_req,
        output addr,
        output flush,
        output mem_data,
        input  rd_data,
        input  miss,
        input  mem_addr
    );

    // Cache controller side
    modport slave (
        input  rd_req,
        input  addr,
        input  flush,
        input  mem_data,
        output rd_data,
        output miss,
        output mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Direct-mapped instruction cache with line refill from a
//               one-cycle-latency backing memory. Define ICACHE_PERF_CNT_EN to
//               add hit_count / miss_count performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    icache_refill_ctrl_if.slave     bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int c_LINES   = 1 << SET_ADDR_LEN;
    localparam int c_ENTRIES = 1 << (LINE_ADDR_LEN + SET_ADDR_LEN);
    localparam int c_TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN:0] c_CNT_LAST = (LINE_ADDR_LEN+1)'(1) << LINE_ADDR_LEN;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [LINE_ADDR_LEN:0]     r_cnt;
    logic [c_TAG_LEN-1:0]       r_miss_tag;
    logic [SET_ADDR_LEN-1:0]    r_miss_set;
    logic [c_LINES-1:0]         r_valid;
    logic [c_TAG_LEN-1:0]       r_tag  [c_LINES];
    logic [31:0]                r_data [c_ENTRIES];

    logic [c_TAG_LEN-1:0]       w_tag;
    logic [SET_ADDR_LEN-1:0]    w_set;
    logic [LINE_ADDR_LEN-1:0]   w_word;
    logic [LINE_ADDR_LEN-1:0]   w_wr_word;
    logic                       w_hit;
    logic                       w_start;
    logic                       w_fill_done;
    logic                       w_flush_all;
    logic                       w_wr_en;

    assign w_tag  = bus.addr[31:2+LINE_ADDR_LEN+SET_ADDR_LEN];
    assign w_set  = bus.addr[1+LINE_ADDR_LEN+SET_ADDR_LEN:2+LINE_ADDR_LEN];
    assign w_word = bus.addr[1+LINE_ADDR_LEN:2];

    assign w_hit = (r_state == S_IDLE) && r_valid[w_set] && (r_tag[w_set] == w_tag);

    assign bus.rd_data  = w_hit ? r_data[{w_set, w_word}] : 32'h0;
    assign bus.miss     = (bus.rd_req && !w_hit) || (r_state != S_IDLE);
    assign bus.mem_addr = (r_state == S_REFILL)
                        ? {r_miss_tag, r_miss_set, r_cnt[LINE_ADDR_LEN-1:0]}
                        : bus.addr;

    // Memory data lags mem_addr by one cycle, so count value N carries word N-1.
    assign w_wr_word = r_cnt[LINE_ADDR_LEN-1:0] - LINE_ADDR_LEN'(1);
    assign w_wr_en   = (r_state == S_REFILL) && (r_cnt != '0) && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fill_done = 1'b0;
        w_flush_all = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.flush) begin
                    w_flush_all = 1'b1;
                end else if (bus.rd_req && !w_hit) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                // Flush aborts the refill; the partially written line stays invalid.
                if (bus.flush) begin
                    w_flush_all = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_miss_tag <= '0;
            r_miss_set <= '0;
            r_valid    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_miss_tag <= w_tag;
                r_miss_set <= w_set;
                r_cnt      <= '0;
            end else if (r_state == S_REFILL) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_flush_all) begin
                r_valid <= '0;
            end else if (w_fill_done) begin
                r_valid[r_miss_set] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_data[{r_miss_set, w_wr_word}] <= bus.mem_data;
        end
        if (w_fill_done && !rst) begin
            r_tag[r_miss_set] <= r_miss_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (bus.rd_req && w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Self-checking bench for icache_refill_ctrl: directed scenarios
//               followed by randomized fetches against a line-level cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    localparam int L     = 3;
    localparam int S     = 4;
    localparam int NW    = 1 << L;
    localparam int NSETS = 1 << S;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    icache_refill_ctrl_if bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_refill_ctrl #(
        .LINE_ADDR_LEN (L),
        .SET_ADDR_LEN  (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: one-cycle read latency, content derived from the address.
    always @(posedge clk) bus.mem_data <= {16'hA5A5, bus.mem_addr[17:2]};

    // Line-level reference model
    bit          m_valid [NSETS];
    int          m_tag   [NSETS];
    bit          m_busy;
    int          m_k;
    int          m_line;
    int unsigned m_hits;
    int unsigned m_misses;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic step(input logic rq, input logic [29:0] a, input logic fl, input logic rs);
        logic        hit;
        logic [29:0] exp_ma;
        int          set;
        int          tag;
        @(negedge clk);
        bus.rd_req = rq;
        bus.addr   = a;
        bus.flush  = fl;
        rst        = rs;
        #1;
        set = int'(a >> L) % NSETS;
        tag = int'(a >> (L + S));
        hit = 1'b0;
        if (m_busy) begin
            chk("miss_refill", {31'd0, bus.miss}, 32'd1);
            chk("rd_data_refill", bus.rd_data, 32'd0);
            exp_ma = 30'((m_line * NW) + (m_k % NW));
        end else begin
            hit = m_valid[set] && (m_tag[set] == tag);
            chk("miss_idle", {31'd0, bus.miss}, {31'd0, rq && !hit});
            chk("rd_data_idle", bus.rd_data, hit ? mem_word(a) : 32'd0);
            exp_ma = a;
        end
        chk("mem_addr", {2'b00, bus.mem_addr}, {2'b00, exp_ma});
`ifdef ICACHE_PERF_CNT_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
        if (rs) begin
            model_clear();
            m_busy   = 1'b0;
            m_hits   = 0;
            m_misses = 0;
        end else if (m_busy) begin
            if (fl) begin
                model_clear();
                m_busy = 1'b0;
            end else if (m_k == NW) begin
                m_valid[m_line % NSETS] = 1'b1;
                m_tag[m_line % NSETS]   = m_line / NSETS;
                m_busy = 1'b0;
            end else begin
                m_k++;
            end
        end else begin
            if (rq && hit) m_hits++;
            if (fl) begin
                model_clear();
            end else if (rq && !hit) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_line = int'(a >> L);
                m_misses++;
            end
        end
    endtask

    // Holds a fetch until miss drops; n is the number of miss-high cycles.
    task automatic count_miss(input logic [29:0] a, output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, a, 1'b0, 1'b0);
            if (bus.miss !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [29:0] ra;
        checks   = 0;
        failures = 0;
        rst        = 1'b1;
        bus.rd_req = 1'b0;
        bus.addr   = '0;
        bus.flush  = 1'b0;
        repeat (3) @(posedge clk);
        model_clear();
        m_busy   = 1'b0;
        m_k      = 0;
        m_line   = 0;
        m_hits   = 0;
        m_misses = 0;

        step(1'b0, 30'd0, 1'b0, 1'b1);
        step(1'b0, 30'd0, 1'b0, 1'b0);
        chk("idle_no_req_miss", {31'd0, bus.miss}, 32'd0);

        // Cold miss on word 0, then a hit in the same line
        count_miss(30'd0, n);
        chk("penalty_line0", n, 32'd10);
        chk("fill_return_data", bus.rd_data, 32'hA5A50000);
        step(1'b1, 30'd5, 1'b0, 1'b0);
        chk("hit_word5_data", bus.rd_data, 32'hA5A50005);
        chk("hit_word5_miss", {31'd0, bus.miss}, 32'd0);
        chk("hit_word5_memaddr", {2'b00, bus.mem_addr}, 32'd5);
`ifdef ICACHE_PERF_CNT_EN
        step(1'b0, 30'd0, 1'b0, 1'b0);
        chk("perf_hits_after_fill", hit_count, 32'd2);
        chk("perf_misses_after_fill", miss_count, 32'd1);
`endif

        // Conflicting tag in set 0 replaces the line
        count_miss(30'h80, n);
        chk("penalty_conflict", n, 32'd10);
        step(1'b1, 30'd0, 1'b0, 1'b0);
        chk("evicted_line_misses", {31'd0, bus.miss}, 32'd1);
        count_miss(30'd0, n);
        chk("penalty_refetch", n, 32'd9);

        // Flush on the 4th refill cycle aborts the refill
        step(1'b1, 30'h10, 1'b0, 1'b0);
        repeat (3) step(1'b1, 30'h10, 1'b0, 1'b0);
        step(1'b1, 30'h10, 1'b1, 1'b0);
        step(1'b0, 30'h10, 1'b0, 1'b0);
        chk("flush_abort_idle", {31'd0, bus.miss}, 32'd0);
        count_miss(30'h10, n);
        chk("penalty_after_flush", n, 32'd10);

        // Reset on the 6th refill cycle leaves a cold cache
        step(1'b1, 30'h20, 1'b0, 1'b0);
        repeat (5) step(1'b1, 30'h20, 1'b0, 1'b0);
        step(1'b1, 30'h20, 1'b0, 1'b1);
        step(1'b1, 30'h10, 1'b0, 1'b0);
        chk("post_reset_miss", {31'd0, bus.miss}, 32'd1);

        // Random traffic over four tags so hits, conflicts and aborts all occur
        for (int i = 0; i < 3000; i++) begin
            ra = 30'($urandom_range(0, 511));
            step($urandom_range(0, 99) < 80,
                 ra,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
